// File: rtl/spi_master.sv
// spi_master: byte-oriented SPI master. Serialises in_data onto mosi while
// capturing miso, holding select across bytes until a byte tagged last ends.
// Ports: clk, reset (async, active high); in_data/in_valid/in_last/in_ready
// byte input handshake; out_data/out_valid received byte pulse; busy;
// select/mclk/mosi/miso SPI bus.
// Params: DIV (mclk half-period, 1..255), CPOL (idle level), CPHA.
// Option: define SPI_MASTER_LSBFIRST_EN to shift LSB first (default MSB).

module spi_master #(
    parameter int DIV  = 2,
    parameter bit CPOL = 1'b1,
    parameter bit CPHA = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       busy,
    output logic       select,
    output logic       mclk,
    output logic       mosi,
    input  logic       miso
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    logic [2:0] r_state;
    logic [7:0] r_div;
    logic [3:0] r_edges;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic       r_last;
    logic       r_fin;
    logic       r_sel;
    logic       r_mclk;
    logic       r_mosi;
    logic [7:0] r_out;
    logic       r_ov;

    logic       w_accept;
    logic       w_tick;
    logic       w_lead;
    logic       w_shift_edge;
    logic       w_sample_edge;
    logic       w_final;
    logic       w_tx_bit;
    logic [7:0] w_tx_shifted;
    logic       w_in_bit;
    logic [7:0] w_in_shifted;
    logic [7:0] w_rx_next;

`ifdef SPI_MASTER_LSBFIRST_EN
    assign w_tx_bit     = r_tx[0];
    assign w_tx_shifted = {1'b0, r_tx[7:1]};
    assign w_in_bit     = in_data[0];
    assign w_in_shifted = {1'b0, in_data[7:1]};
    assign w_rx_next    = {miso, r_rx[7:1]};
`else
    assign w_tx_bit     = r_tx[7];
    assign w_tx_shifted = {r_tx[6:0], 1'b0};
    assign w_in_bit     = in_data[7];
    assign w_in_shifted = {in_data[6:0], 1'b0};
    assign w_rx_next    = {r_rx[6:0], miso};
`endif

    assign in_ready  = ((r_state == S_IDLE) | (r_state == S_NEXT)) & ~reset;
    assign busy      = (r_state != S_IDLE);
    assign select    = r_sel;
    assign mclk      = r_mclk;
    assign mosi      = r_mosi;
    assign out_data  = r_out;
    assign out_valid = r_ov;

    assign w_accept = in_valid & in_ready;
    assign w_tick   = (r_div == DIV_LAST);
    // r_edges counts edges already made; an even count means the edge
    // about to be made is a leading one (mclk leaves its idle level).
    assign w_lead        = ~r_edges[0];
    assign w_shift_edge  = CPHA ? w_lead : ~w_lead;
    assign w_sample_edge = ~w_shift_edge;
    assign w_final       = (r_edges == 4'd15);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_div   <= 8'd0;
            r_edges <= 4'd0;
            r_tx    <= 8'd0;
            r_rx    <= 8'd0;
            r_last  <= 1'b0;
            r_fin   <= 1'b0;
            r_sel   <= 1'b0;
            r_mclk  <= CPOL;
            r_mosi  <= 1'b0;
            r_out   <= 8'd0;
            r_ov    <= 1'b0;
        end else begin
            // Byte completion is flagged at the 16th edge and published
            // one cycle later, once the final sample is in r_rx.
            r_ov  <= r_fin;
            r_fin <= 1'b0;
            if (r_fin) begin
                r_out <= r_rx;
            end

            if (w_accept) begin
                r_last <= in_last;
                if (!CPHA) begin
                    // Sample-first mode needs the first bit on the
                    // wire before the leading edge.
                    r_mosi <= w_in_bit;
                    r_tx   <= w_in_shifted;
                end else begin
                    r_tx <= in_data;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sel   <= 1'b1;
                        r_div   <= 8'd0;
                        r_edges <= 4'd0;
                        r_state <= S_SETUP;
                    end
                end
                S_NEXT: begin
                    if (w_accept) begin
                        r_div   <= 8'd0;
                        r_edges <= 4'd0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SETUP, S_SHIFT: begin
                    if (w_tick) begin
                        r_div   <= 8'd0;
                        r_mclk  <= ~r_mclk;
                        r_edges <= r_edges + 4'd1;
                        // The 16th edge never shifts: all 8 bits are out.
                        if (w_shift_edge && !w_final) begin
                            r_mosi <= w_tx_bit;
                            r_tx   <= w_tx_shifted;
                        end
                        if (w_sample_edge) begin
                            r_rx <= w_rx_next;
                        end
                        if (w_final) begin
                            r_fin   <= 1'b1;
                            r_state <= r_last ? S_HOLD : S_NEXT;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (w_tick) begin
                        r_div   <= 8'd0;
                        r_sel   <= 1'b0;
                        r_state <= S_GAP;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        r_div   <= 8'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master, CPOL=1/CPHA=1 against a
// slave model and CPOL=0/CPHA=0 in loopback.

module tb_spi_master;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] id_a, od_a, id_b, od_b;
    logic iv_a, il_a, ir_a, ov_a, busy_a, sel_a, mclk_a, mosi_a, miso_a;
    logic iv_b, il_b, ir_b, ov_b, busy_b, sel_b, mclk_b, mosi_b, miso_b;
    logic loop_a;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master #(.DIV(2), .CPOL(1'b1), .CPHA(1'b1)) u_a (
        .clk(clk), .reset(reset),
        .in_data(id_a), .in_valid(iv_a), .in_last(il_a), .in_ready(ir_a),
        .out_data(od_a), .out_valid(ov_a), .busy(busy_a),
        .select(sel_a), .mclk(mclk_a), .mosi(mosi_a), .miso(miso_a)
    );

    spi_master #(.DIV(2), .CPOL(1'b0), .CPHA(1'b0)) u_b (
        .clk(clk), .reset(reset),
        .in_data(id_b), .in_valid(iv_b), .in_last(il_b), .in_ready(ir_b),
        .out_data(od_b), .out_valid(ov_b), .busy(busy_b),
        .select(sel_b), .mclk(mclk_b), .mosi(mosi_b), .miso(miso_b)
    );

    assign miso_b = mosi_b;

    // Slave model for CPOL=1, CPHA=1, MSB first.
    logic [7:0] s_tx = 8'd0;
    logic [7:0] s_rx = 8'd0;
    logic       s_miso = 1'b0;
    int         s_n = 0;
    logic [7:0] s_txq[$];
    logic [7:0] s_log[$];

    assign miso_a = loop_a ? mosi_a : s_miso;

    always @(posedge sel_a) begin
        s_n = 0;
        if (s_txq.size() > 0) s_tx = s_txq.pop_front();
    end

    always @(mclk_a) begin
        if (sel_a === 1'b1 && reset === 1'b0) begin
            if (mclk_a === 1'b0) begin
                s_miso = s_tx[7];
                s_tx   = {s_tx[6:0], 1'b0};
            end else begin
                s_rx = {s_rx[6:0], mosi_a};
                s_n++;
                if (s_n == 8) begin
                    s_log.push_back(s_rx);
                    s_n = 0;
                    if (s_txq.size() > 0) s_tx = s_txq.pop_front();
                end
            end
        end
    end

    // Bus monitors.
    logic [7:0] ov_q[$];
    int         ov_cyc[$];
    logic [7:0] ovb_q[$];
    int         edges_a = 0;
    int         sel_falls = 0;
    int         sel_fall_cyc = 0;
    logic       pm_a = 1'b1;
    logic       ps_a = 1'b0;

    always @(negedge clk) begin
        if (ov_a === 1'b1) begin
            ov_q.push_back(od_a);
            ov_cyc.push_back(cyc);
        end
        if (ov_b === 1'b1) ovb_q.push_back(od_b);
        if (mclk_a !== pm_a) edges_a++;
        pm_a = mclk_a;
        if (ps_a === 1'b1 && sel_a === 1'b0) begin
            sel_falls++;
            sel_fall_cyc = cyc;
        end
        ps_a = sel_a;
    end

    function automatic logic [7:0] ord(input logic [7:0] x);
`ifdef SPI_MASTER_LSBFIRST_EN
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
`else
        return x;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input int u, input logic [7:0] d, input logic last,
                        output int c0);
        bit ok;
        ok = 1'b0;
        c0 = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if ((u == 0) ? ir_a : ir_b) begin
                ok = 1'b1;
                c0 = cyc;
                if (u == 0) begin
                    iv_a = 1'b1; id_a = d; il_a = last;
                end else begin
                    iv_b = 1'b1; id_b = d; il_b = last;
                end
            end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        iv_a = 1'b0;
        iv_b = 1'b0;
    endtask

    task automatic wait_idle(input int u, input int c0, input bit noise,
                             output int rdy, output bit nbad);
        bit done;
        int rel;
        done = 1'b0;
        nbad = 1'b0;
        rdy  = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            rel = cyc - c0;
            if (noise) begin
                if (rel >= 5 && rel <= 10) begin
                    iv_a = 1'b1; id_a = 8'hFF; il_a = 1'b0;
                    if (ir_a !== 1'b0) nbad = 1'b1;
                end else begin
                    iv_a = 1'b0;
                end
            end
            if ((u == 0) ? (ir_a && !busy_a) : (ir_b && !busy_b)) begin
                done = 1'b1;
                rdy  = rel;
            end
        end
        iv_a = 1'b0;
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] stx;
        logic [7:0] exp_out;
        logic [7:0] exp_srx;
        bit         noise;
    } vec_t;

    vec_t vt[5];

    initial begin
        int c0, rdy, rel;
        bit nbad, bad;
        logic [7:0] fb;

        vt[0] = '{tx: 8'hCD, stx: 8'h89, exp_out: 8'h89, exp_srx: 8'hCD, noise: 1'b0};
        vt[1] = '{tx: 8'h00, stx: 8'hFF, exp_out: 8'hFF, exp_srx: 8'h00, noise: 1'b1};
        vt[2] = '{tx: 8'hFF, stx: 8'h00, exp_out: 8'h00, exp_srx: 8'hFF, noise: 1'b0};
        vt[3] = '{tx: 8'hA5, stx: 8'h5A, exp_out: 8'h5A, exp_srx: 8'hA5, noise: 1'b0};
        vt[4] = '{tx: 8'h80, stx: 8'h01, exp_out: 8'h01, exp_srx: 8'h80, noise: 1'b0};

        reset = 1'b0;
        loop_a = 1'b0;
        iv_a = 1'b0; id_a = 8'h00; il_a = 1'b0;
        iv_b = 1'b0; id_b = 8'h00; il_b = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ir_a}, 32'd0);
        check("rst_select", {31'd0, sel_a}, 32'd0);
        check("rst_mclk_a", {31'd0, mclk_a}, 32'd1);
        check("rst_mclk_b", {31'd0, mclk_b}, 32'd0);
        check("rst_mosi", {31'd0, mosi_a}, 32'd0);
        check("rst_out", {24'd0, od_a}, 32'd0);
        check("rst_valid", {31'd0, ov_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", {31'd0, ir_a}, 32'd1);

        // Single-byte transactions against the slave model.
        for (int i = 0; i < 5; i++) begin
            ov_q.delete(); ov_cyc.delete(); s_log.delete();
            edges_a = 0;
            s_txq.push_back(vt[i].stx);
            send(0, vt[i].tx, 1'b1, c0);
            wait_idle(0, c0, vt[i].noise, rdy, nbad);
            check("ov_count", ov_q.size(), 32'd1);
            if (ov_q.size() > 0) begin
                check("out_data", {24'd0, ov_q[0]}, {24'd0, ord(vt[i].exp_out)});
                check("ov_cycle", ov_cyc[0] - c0, 32'd34);
            end
            check("sel_fall", sel_fall_cyc - c0, 32'd35);
            check("ready_cycle", rdy, 32'd37);
            check("edges", edges_a, 32'd16);
            check("slave_rx_n", s_log.size(), 32'd1);
            if (s_log.size() > 0)
                check("slave_rx", {24'd0, s_log[0]}, {24'd0, ord(vt[i].exp_srx)});
            if (vt[i].noise) check("busy_ready", {31'd0, nbad}, 32'd0);
        end

        // Two bytes, select held across the boundary.
        ov_q.delete(); s_log.delete();
        edges_a = 0; sel_falls = 0;
        s_txq.push_back(8'h12); s_txq.push_back(8'h34);
        send(0, 8'h56, 1'b0, c0);
        send(0, 8'h78, 1'b1, c0);
        wait_idle(0, c0, 1'b0, rdy, nbad);
        check("two_n", ov_q.size(), 32'd2);
        if (ov_q.size() > 1) begin
            check("two_out0", {24'd0, ov_q[0]}, {24'd0, ord(8'h12)});
            check("two_out1", {24'd0, ov_q[1]}, {24'd0, ord(8'h34)});
        end
        if (s_log.size() > 1) begin
            check("two_srx0", {24'd0, s_log[0]}, {24'd0, ord(8'h56)});
            check("two_srx1", {24'd0, s_log[1]}, {24'd0, ord(8'h78)});
        end else check("two_srx_n", s_log.size(), 32'd2);
        check("two_sel_falls", sel_falls, 32'd1);
        check("two_edges", edges_a, 32'd32);

        // Stall 50 cycles in NEXT.
        ov_q.delete(); s_log.delete();
        edges_a = 0; sel_falls = 0;
        s_txq.push_back(8'h9C); s_txq.push_back(8'h3E);
        send(0, 8'h6B, 1'b0, c0);
        bad = 1'b0;
        for (int k = 0; k < 200 && !ir_a; k++) @(negedge clk);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sel_a !== 1'b1 || mclk_a !== 1'b1 || ir_a !== 1'b1) bad = 1'b1;
        end
        check("stall_hold", {31'd0, bad}, 32'd0);
        send(0, 8'hD2, 1'b1, c0);
        wait_idle(0, c0, 1'b0, rdy, nbad);
        check("stall_n", ov_q.size(), 32'd2);
        if (ov_q.size() > 1) begin
            check("stall_out0", {24'd0, ov_q[0]}, {24'd0, ord(8'h9C)});
            check("stall_out1", {24'd0, ov_q[1]}, {24'd0, ord(8'h3E)});
        end
        if (s_log.size() > 1)
            check("stall_srx1", {24'd0, s_log[1]}, {24'd0, ord(8'hD2)});
        else check("stall_srx_n", s_log.size(), 32'd2);
        check("stall_edges", edges_a, 32'd32);
        check("stall_sel_falls", sel_falls, 32'd1);

        // Reset at the 7th mclk edge (visible in cycle 15).
        ov_q.delete();
        loop_a = 1'b1;
        send(0, 8'hA5, 1'b1, c0);
        rel = 0;
        for (int k = 0; k < 100 && rel < 15; k++) begin
            @(negedge clk);
            rel = cyc - c0;
        end
        check("pre_rst_mclk", {31'd0, mclk_a}, 32'd0);
        reset = 1'b1;
        #1;
        check("abort_select", {31'd0, sel_a}, 32'd0);
        check("abort_mclk", {31'd0, mclk_a}, 32'd1);
        check("abort_mosi", {31'd0, mosi_a}, 32'd0);
        check("abort_valid", {31'd0, ov_a}, 32'd0);
        check("abort_out", {24'd0, od_a}, 32'd0);
        check("abort_busy", {31'd0, busy_a}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_ov", ov_q.size(), 32'd0);
        send(0, 8'hA5, 1'b1, c0);
        wait_idle(0, c0, 1'b0, rdy, nbad);
        check("after_rst_n", ov_q.size(), 32'd1);
        if (ov_q.size() > 0) check("after_rst_out", {24'd0, ov_q[0]}, 32'hA5);

`ifdef SPI_MASTER_LSBFIRST_EN
        ov_q.delete(); s_log.delete();
        send(0, 8'h01, 1'b1, c0);
        wait_idle(0, c0, 1'b0, rdy, nbad);
        if (s_log.size() > 0) check("lsb_mosi", {24'd0, s_log[0]}, 32'h80);
        else check("lsb_mosi_n", s_log.size(), 32'd1);
        if (ov_q.size() > 0) check("lsb_out", {24'd0, ov_q[0]}, 32'h01);
        else check("lsb_out_n", ov_q.size(), 32'd1);
`endif
        loop_a = 1'b0;

        // CPOL=0, CPHA=0 loopback.
        for (int i = 0; i < 2; i++) begin
            logic [7:0] d;
            d = (i == 0) ? 8'h3C : 8'hC3;
            fb = ord(d);
            ovb_q.delete();
            check("b_idle_mclk", {31'd0, mclk_b}, 32'd0);
            send(1, d, 1'b1, c0);
            @(negedge clk);
            check("b_first_bit", {31'd0, mosi_b}, {31'd0, fb[7]});
            @(negedge clk);
            check("b_bit_held", {31'd0, mosi_b}, {31'd0, fb[7]});
            check("b_pre_edge", {31'd0, mclk_b}, 32'd0);
            wait_idle(1, c0, 1'b0, rdy, nbad);
            check("b_n", ovb_q.size(), 32'd1);
            if (ovb_q.size() > 0) check("b_out", {24'd0, ovb_q[0]}, {24'd0, d});
            check("b_ready", rdy, 32'd37);
            check("b_end_mclk", {31'd0, mclk_b}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
